// File: rtl/pin_entry_verifier_if.sv
// Bundle between the payment FSM / keypad and the PIN entry verifier.
// master: payment FSM and keypad side; slave: the verifier.
interface pin_entry_verifier_if #(
   parameter int PIN_DIGITS = 4
);
   localparam int CNT_W = $clog2(PIN_DIGITS + 1);

   logic                    pin_process_init;
   logic [4*PIN_DIGITS-1:0] ref_pin;
   logic                    key_valid;
   logic [3:0]              key_digit;
   logic                    key_clear;
   logic                    key_enter;
   logic                    pin_success;
   logic                    pin_fail;
   logic                    timeout_flag;
   logic                    pin_busy;
   logic [CNT_W-1:0]        digit_count;

   modport master (
      output pin_process_init, ref_pin, key_valid, key_digit, key_clear, key_enter,
      input  pin_success, pin_fail, timeout_flag, pin_busy, digit_count
   );

   modport slave (
      input  pin_process_init, ref_pin, key_valid, key_digit, key_clear, key_enter,
      output pin_success, pin_fail, timeout_flag, pin_busy, digit_count
   );
endinterface

// File: rtl/pin_entry_verifier.sv
// PIN entry verifier: collects keypad digits for one attempt, compares them
// with the card's reference PIN and returns a single-cycle success/fail pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for pin_process_init; key strobes ignored
// COLLECT | accepting digits; inter-key timer running down
// CHECK   | one cycle: compare entry against ref_pin
// DONE    | one cycle: result pulse visible, then back to IDLE
module pin_entry_verifier #(
   parameter int PIN_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TIMER_W        = 10
) (
   input logic                 clk,
   input logic                 reset,
   pin_entry_verifier_if.slave bus
);
   localparam int                 CNT_W      = $clog2(PIN_DIGITS + 1);
   localparam int                 BUF_W      = 4 * PIN_DIGITS;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(PIN_DIGITS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t             state, state_next;
   logic [BUF_W-1:0]   buffer, buffer_next;
   logic [CNT_W-1:0]   count, count_next;
   logic [TIMER_W-1:0] timer, timer_next;
   logic               success, success_next;
   logic               fail, fail_next;
   logic               tmo, tmo_next;
   logic               busy, busy_next;
   logic               digit_ok;

   // A digit counts only if it is BCD and the entry is not yet full.
   assign digit_ok = bus.key_valid && (bus.key_digit <= 4'd9) && (count < CNT_FULL);

   // State and datapath registers; every output comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         buffer  <= '0;
         count   <= '0;
         timer   <= '0;
         success <= 1'b0;
         fail    <= 1'b0;
         tmo     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         buffer  <= buffer_next;
         count   <= count_next;
         timer   <= timer_next;
         success <= success_next;
         fail    <= fail_next;
         tmo     <= tmo_next;
         busy    <= busy_next;
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_next   = state;
      buffer_next  = buffer;
      count_next   = count;
      timer_next   = timer;
      success_next = 1'b0;
      fail_next    = 1'b0;
      tmo_next     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.pin_process_init) begin
               state_next  = S_COLLECT;
               buffer_next = '0;
               count_next  = '0;
               timer_next  = TIMER_LOAD;
            end
         end
         S_COLLECT: begin
            // Upstream abort outranks any key activity in the same cycle.
            if (!bus.pin_process_init) begin
               state_next  = S_IDLE;
               buffer_next = '0;
               count_next  = '0;
            end else if (bus.key_clear) begin
               buffer_next = '0;
               count_next  = '0;
               timer_next  = TIMER_LOAD;
            end else if (bus.key_enter) begin
               state_next = S_CHECK;
            end else if (digit_ok) begin
               buffer_next = {buffer[BUF_W-5:0], bus.key_digit};
               count_next  = count + CNT_W'(1);
               timer_next  = TIMER_LOAD;
            end else if (timer == '0) begin
               state_next = S_DONE;
               fail_next  = 1'b1;
               tmo_next   = 1'b1;
            end else begin
               timer_next = timer - TIMER_W'(1);
            end
         end
         S_CHECK: begin
            state_next = S_DONE;
            if ((count == CNT_FULL) && (buffer == bus.ref_pin)) begin
               success_next = 1'b1;
            end else begin
               fail_next = 1'b1;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      busy_next = (state_next == S_COLLECT) || (state_next == S_CHECK);
   end

   assign bus.pin_success  = success;
   assign bus.pin_fail     = fail;
   assign bus.timeout_flag = tmo;
   assign bus.pin_busy     = busy;
   assign bus.digit_count  = count;
endmodule

// File: tb/tb_pin_entry_verifier.sv
// Bench for pin_entry_verifier: directed walk through the attempt scenarios,
// then randomized key traffic, all compared every cycle against an
// attempt-level reference model.
module tb_pin_entry_verifier;
   localparam int PIN_DIGITS = 4;
   localparam int TIMEOUT    = 8;

   localparam int P_IDLE    = 0;
   localparam int P_COLLECT = 1;
   localparam int P_CHECK   = 2;
   localparam int P_DONE    = 3;

   logic clk;
   logic reset;

   pin_entry_verifier_if #(.PIN_DIGITS(PIN_DIGITS)) bus ();

   pin_entry_verifier #(
      .PIN_DIGITS    (PIN_DIGITS),
      .TIMEOUT_CYCLES(TIMEOUT),
      .TIMER_W       (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: the attempt as a list of entered digits plus an idle count
   int phase;
   int digs[$];
   int idle;
   int m_succ, m_fail, m_tmo;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_digit(input int i);
      return int'((bus.ref_pin >> (4 * (PIN_DIGITS - 1 - i))) & 16'hF);
   endfunction

   function automatic void model_reset();
      phase  = P_IDLE;
      digs.delete();
      idle   = 0;
      m_succ = 0;
      m_fail = 0;
      m_tmo  = 0;
   endfunction

   function automatic void model_edge();
      bit ok;
      m_succ = 0;
      m_fail = 0;
      m_tmo  = 0;
      case (phase)
         P_IDLE: begin
            if (bus.pin_process_init) begin
               phase = P_COLLECT;
               digs.delete();
               idle = 0;
            end
         end
         P_COLLECT: begin
            if (!bus.pin_process_init) begin
               phase = P_IDLE;
               digs.delete();
            end else if (bus.key_clear) begin
               digs.delete();
               idle = 0;
            end else if (bus.key_enter) begin
               phase = P_CHECK;
            end else if (bus.key_valid && int'(bus.key_digit) < 10 && digs.size() < PIN_DIGITS) begin
               digs.push_back(int'(bus.key_digit));
               idle = 0;
            end else if (idle == TIMEOUT - 1) begin
               phase  = P_DONE;
               m_fail = 1;
               m_tmo  = 1;
            end else begin
               idle++;
            end
         end
         P_CHECK: begin
            ok = (digs.size() == PIN_DIGITS);
            if (ok) begin
               for (int i = 0; i < PIN_DIGITS; i++) begin
                  if (digs[i] != ref_digit(i)) ok = 0;
               end
            end
            m_succ = ok ? 1 : 0;
            m_fail = ok ? 0 : 1;
            phase  = P_DONE;
         end
         default: phase = P_IDLE;
      endcase
   endfunction

   // one clock: model follows the edge, outputs compared 1 time unit later
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("pin_success", int'(bus.pin_success), m_succ);
      check_eq("pin_fail", int'(bus.pin_fail), m_fail);
      check_eq("timeout_flag", int'(bus.timeout_flag), m_tmo);
      check_eq("pin_busy", int'(bus.pin_busy), (phase == P_COLLECT || phase == P_CHECK) ? 1 : 0);
      check_eq("digit_count", int'(bus.digit_count), digs.size());
      bus.key_valid = 1'b0;
      bus.key_clear = 1'b0;
      bus.key_enter = 1'b0;
   endtask

   task automatic press(input int d);
      bus.key_valid = 1'b1;
      bus.key_digit = 4'(d);
      step();
   endtask

   task automatic press_pin(input int a, input int b, input int c, input int d);
      press(a); press(b); press(c); press(d);
   endtask

   // enter, then the CHECK and DONE edges; result checked on the DONE cycle
   task automatic submit(input string tag, input int exp_succ);
      bus.key_enter = 1'b1;
      step();
      step();
      check_eq({tag, "_success"}, int'(bus.pin_success), exp_succ);
      check_eq({tag, "_fail"}, int'(bus.pin_fail), 1 - exp_succ);
   endtask

   // drop init long enough to land in IDLE, load a new reference, restart
   task automatic new_session(input logic [15:0] pin);
      bus.pin_process_init = 1'b0;
      step(); step(); step();
      bus.ref_pin          = pin;
      bus.pin_process_init = 1'b1;
      step();
   endtask

   initial begin
      int n;
      reset                = 1'b0;
      bus.pin_process_init = 1'b0;
      bus.ref_pin          = 16'h1234;
      bus.key_valid        = 1'b0;
      bus.key_digit        = 4'd0;
      bus.key_clear        = 1'b0;
      bus.key_enter        = 1'b0;
      model_reset();
      #12;
      check_eq("rst_success", int'(bus.pin_success), 0);
      check_eq("rst_fail", int'(bus.pin_fail), 0);
      check_eq("rst_busy", int'(bus.pin_busy), 0);
      check_eq("rst_count", int'(bus.digit_count), 0);
      reset = 1'b1;
      step();

      // correct PIN
      new_session(16'h1234);
      check_eq("start_busy", int'(bus.pin_busy), 1);
      press_pin(1, 2, 3, 4);
      check_eq("count_4", int'(bus.digit_count), 4);
      submit("correct", 1);
      step();
      check_eq("one_cycle_pulse", int'(bus.pin_success), 0);

      // wrong PIN, then retry with init held
      step();
      press_pin(1, 2, 3, 5);
      submit("wrong", 0);
      step();
      check_eq("retry_idle_busy", int'(bus.pin_busy), 0);
      step();
      check_eq("retry_busy", int'(bus.pin_busy), 1);
      press_pin(1, 2, 3, 4);
      submit("retry", 1);
      step(); step();

      // short entry
      press(1); press(2); press(3);
      submit("short", 0);
      step(); step();

      // over-length entry: fifth digit ignored
      press_pin(1, 2, 3, 4);
      press(9);
      check_eq("over_count", int'(bus.digit_count), 4);
      submit("over", 1);
      step(); step();

      // invalid digit
      press(1);
      press(4'hA);
      check_eq("invalid_count", int'(bus.digit_count), 1);
      press(2); press(3); press(4);
      submit("invalid_then_ok", 1);
      step(); step();

      // clear wins over enter
      press(7); press(7);
      bus.key_clear = 1'b1;
      bus.key_enter = 1'b1;
      step();
      check_eq("clear_count", int'(bus.digit_count), 0);
      check_eq("clear_busy", int'(bus.pin_busy), 1);
      press_pin(1, 2, 3, 4);
      submit("after_clear", 1);

      // timeout with no keys
      new_session(16'h1234);
      n = 1;
      while (!bus.pin_fail && n < 20) begin
         step();
         n++;
      end
      check_eq("tmo_latency", n, TIMEOUT + 1);
      check_eq("tmo_flag", int'(bus.timeout_flag), 1);

      // key after five idle cycles restarts the countdown
      new_session(16'h1234);
      for (int i = 0; i < 5; i++) step();
      press(3);
      n = 0;
      while (!bus.pin_fail && n < 20) begin
         step();
         n++;
      end
      check_eq("tmo_restart", n, TIMEOUT);

      // abort after two digits
      new_session(16'h1234);
      press(1); press(2);
      bus.pin_process_init = 1'b0;
      step();
      check_eq("abort_busy", int'(bus.pin_busy), 0);
      check_eq("abort_count", int'(bus.digit_count), 0);

      // asynchronous reset mid-COLLECT
      new_session(16'h5678);
      press(5); press(6);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_busy", int'(bus.pin_busy), 0);
      check_eq("arst_count", int'(bus.digit_count), 0);
      check_eq("arst_success", int'(bus.pin_success), 0);
      check_eq("arst_fail", int'(bus.pin_fail), 0);
      model_reset();
      #2 reset = 1'b1;
      step();

      // randomized attempts
      for (int a = 0; a < 40; a++) begin
         logic [15:0] pin;
         int ops;
         for (int i = 0; i < PIN_DIGITS; i++) pin = {pin[11:0], 4'($urandom_range(0, 9))};
         new_session(pin);
         ops = $urandom_range(3, 8);
         for (int o = 0; o < ops; o++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55) begin
               press(digs.size() < PIN_DIGITS ? ref_digit(digs.size()) : $urandom_range(0, 9));
            end else if (r < 70) begin
               press($urandom_range(0, 15));
            end else if (r < 76) begin
               bus.key_clear = 1'b1;
               bus.key_enter = ($urandom_range(0, 1) == 1);
               bus.key_valid = ($urandom_range(0, 1) == 1);
               step();
            end else if (r < 92) begin
               for (int g = $urandom_range(1, 3); g > 0; g--) step();
            end else if (r < 96) begin
               for (int g = 0; g < TIMEOUT + 1; g++) step();
            end else begin
               bus.pin_process_init = 1'b0;
               step();
               bus.pin_process_init = 1'b1;
            end
         end
         bus.key_enter = 1'b1;
         bus.key_valid = ($urandom_range(0, 3) == 0);
         step(); step(); step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pin_entry_verifier.md
Name: pin_entry_verifier

Overview:
- Downstream PIN stage of the credit card payment FSM.
- Started by the FSM's pin_process_init. Collects keypad digits, compares them against the card's reference PIN, and returns a one-cycle pin_success or pin_fail pulse.
- The upstream FSM keeps the fail count and decides lockout. This block judges one attempt at a time and re-arms automatically for retries.

Parameters:
- PIN_DIGITS, 4: number of BCD digits in a PIN.
- TIMEOUT_CYCLES, 1000: idle cycles allowed between key events in COLLECT before the attempt fails.
- TIMER_W, 10: timer width; must satisfy 2^TIMER_W >= TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- pin_process_init  input  1  level start/enable from the payment FSM.
- ref_pin  input  4*PIN_DIGITS  expected PIN, BCD; first digit in the most significant nibble. Stable while pin_busy=1.
- key_valid  input  1  one-cycle strobe: key_digit is valid.
- key_digit  input  4  BCD digit 0-9.
- key_clear  input  1  one-cycle strobe: erase entry.
- key_enter  input  1  one-cycle strobe: submit entry.
- pin_success  output  1  one-cycle pulse: PIN matched.
- pin_fail  output  1  one-cycle pulse: mismatch or timeout.
- timeout_flag  output  1  high together with pin_fail when the failure was a timeout.
- pin_busy  output  1  high in COLLECT and CHECK.
- digit_count  output  $clog2(PIN_DIGITS+1)  digits accepted so far, for masked display.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; buffer, digit_count and timer=0; pin_success, pin_fail, timeout_flag, pin_busy=0.
- States: IDLE, COLLECT, CHECK, DONE. All outputs are registered.
- IDLE:
  - If pin_process_init=1, go to COLLECT on the next edge.
  - On that transition: clear buffer, set digit_count=0, load timer=TIMEOUT_CYCLES-1.
  - Key strobes in IDLE are ignored.
- COLLECT: key priority when strobes coincide is key_clear > key_enter > key_valid.
  - key_clear: buffer=0, digit_count=0, timer reloaded, stay in COLLECT.
  - key_enter: go to CHECK.
  - key_valid with key_digit<=9 and digit_count<PIN_DIGITS:
    - buffer <= {buffer[4*PIN_DIGITS-5:0], key_digit}.
    - digit_count+1, timer reloaded.
  - key_valid with key_digit>9, or with digit_count==PIN_DIGITS: ignored, and the timer is not reloaded.
  - No accepted event: timer decrements. If timer==0 with no event, go to DONE as a fail with timeout_flag=1.
  - pin_process_init falls to 0 (upstream abort): go to IDLE. No result pulse; buffer and digit_count cleared.
- CHECK (one cycle):
  - match = (digit_count==PIN_DIGITS) && (buffer==ref_pin).
  - Go to DONE, registering pin_success=match and pin_fail=!match.
- DONE (one cycle):
  - pin_success or pin_fail is high for exactly this cycle. Never both; never two cycles.
  - Next state is IDLE, with outputs cleared.
  - If pin_process_init is still 1 in IDLE, a new attempt begins one cycle later. This is the retry path after pin_fail.
- Latency: key_enter sampled at edge k gives state=CHECK after k, and the result pulse after edge k+1.
- pin_busy=1 in COLLECT and CHECK; 0 in IDLE and DONE.
- Reset asserted mid-attempt aborts immediately. No pulse is produced.
- The buffer is never exposed on a port.

Test Plan:
- Correct PIN: reset, ref_pin=16'h1234, pin_process_init=1, keys 1,2,3,4, then enter.
  - Required: digit_count counts 1..4; pin_success=1 for exactly one cycle, 2 edges after enter; pin_fail=0; timeout_flag=0.
- Wrong PIN and retry: keys 1,2,3,5, then enter.
  - Required: pin_fail one-cycle pulse.
  - With pin_process_init held, pin_busy returns to 1 two cycles after DONE.
  - Second attempt 1,2,3,4 + enter gives pin_success.
- Short entry, over-length entry, invalid digits:
  - Keys 1,2,3 + enter gives pin_fail.
  - Keys 1,2,3,4,9 gives digit_count=4 (extra digit ignored); then enter gives pin_success.
  - key_digit=4'hA leaves digit_count unchanged.
- Clear and simultaneous strobes:
  - Keys 7,7, then key_clear together with key_enter: digit_count=0 and state stays COLLECT (clear wins).
  - Then 1,2,3,4 + enter gives pin_success.
- Timeout: TIMEOUT_CYCLES=8, start the attempt, press no keys.
  - Required: pin_fail=1 and timeout_flag=1 in the same single cycle, 9-10 cycles after start.
  - A key at cycle 6 restarts the 8-cycle countdown.
- Abort and reset:
  - Drop pin_process_init after two digits: IDLE next cycle, no pulse, digit_count=0.
  - Assert reset=0 mid-COLLECT: all outputs 0 immediately, without waiting for a clock edge.
